// File: rtl/jtdd_colmix_pkg.sv
// rtl/jtdd_colmix_pkg.sv - shared constants and layer priority for the Double Dragon colour mixer
//
// Package jtdd_pkg:
//   OBJ_BASE, CHAR_BASE, SCR_BASE : palette index regions of each layer
//   PIPE_DLY                      : pixel pipeline depth in pxl_cen ticks
//   mix_index()                   : fixed-priority palette index from the three layer pixels
package jtdd_pkg;

  localparam logic [8:0] OBJ_BASE  = 9'h000;
  localparam logic [8:0] CHAR_BASE = 9'h100;
  localparam logic [8:0] SCR_BASE  = 9'h180;
  localparam int         PIPE_DLY  = 3;

  // char over obj over scroll. Scroll colour 0 is not transparent: it is the backdrop.
  function automatic logic [8:0] mix_index(input logic [6:0] chr,
                                           input logic [6:0] scr,
                                           input logic [7:0] obj);
    if (chr[3:0] != 4'h0)
      return CHAR_BASE | {2'b00, chr};
    else if (obj[3:0] != 4'h0)
      return OBJ_BASE | {1'b0, obj};
    else
      return SCR_BASE | {2'b00, scr};
  endfunction

endpackage

// File: rtl/jtdd_colmix_if.sv
// rtl/jtdd_colmix_if.sv - CPU palette bus between the main CPU decoder and the colour mixer
//
// Signals:
//   cpu_AB[9:0]  address inside palette area, bit 9 selects RG (0) or B (1) bank
//   pal_cs       palette chip select
//   cpu_wrn      write strobe, active low
//   cpu_dout     CPU write data
//   pal_dout     palette read data back to the CPU
// Modports: master = CPU side, slave = colour mixer side.
interface jtdd_colmix_if;
  logic [9:0] cpu_AB;
  logic       pal_cs;
  logic       cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;

  modport master (output cpu_AB, pal_cs, cpu_wrn, cpu_dout, input pal_dout);
  modport slave  (input cpu_AB, pal_cs, cpu_wrn, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - dual-port RAM: read/write port 0, read-only port 1 with clock enable
//
// Ports:
//   clk0, data0, addr0, we0, q0 : port 0, registered read, write when we0
//   clk1, cen1, addr1, q1       : port 1, registered read advancing only when cen1
// A read on either port of the address port 0 is writing in the same cycle returns
// the old contents. Contents are not initialised.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 9
) (
  input  logic          clk0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic          clk1,
  input  logic          cen1,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk0) begin
    q0 <= mem[addr0];
    if (we0) mem[addr0] <= data0;
  end

  always_ff @(posedge clk1) begin
    if (cen1) q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtdd_colmix.sv
// rtl/jtdd_colmix.sv - Double Dragon colour mixer: layer priority, palette lookup, blank delay
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   pxl_cen             pixel clock enable, the video pipeline advances only on it
//   cpu                 palette CPU bus (jtdd_colmix_if.slave)
//   char_pxl, scr_pxl   {pal[2:0], col[3:0]} layer pixels
//   obj_pxl             {pal[3:0], col[3:0]} object line-buffer pixel
//   HBL, VBL            blanking in, active high
//   gfx_en[2:0]         layer enables {obj, scroll, char}, only when JTDD_LAYERMASK_EN is defined
//   red, green, blue    4-bit colour out, 0 while blanked
//   LHBL_dly, LVBL_dly  blanking delayed to match the pixel path, low during blank
module jtdd_colmix
  import jtdd_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         pxl_cen,
  jtdd_colmix_if.slave cpu,
  input  logic [6:0]   char_pxl,
  input  logic [6:0]   scr_pxl,
  input  logic [7:0]   obj_pxl,
  input  logic         HBL,
  input  logic         VBL,
`ifdef JTDD_LAYERMASK_EN
  input  logic [2:0]   gfx_en,
`endif
  output logic [3:0]   red,
  output logic [3:0]   green,
  output logic [3:0]   blue,
  output logic         LHBL_dly,
  output logic         LVBL_dly
);

  logic [6:0] char_m, scr_m;
  logic [7:0] obj_m;
  logic [8:0] idx_s0;
  logic [7:0] rg_cq, b_cq, rg_vq, b_vq;
  logic       rd_bank, rd_ok;
  logic       we_rg, we_b;
  logic [PIPE_DLY-1:0] lhb, lvb;
  logic       blank_s2;
  logic [3:0] unused_b_hi;

  // A disabled layer keeps its palette bits but loses its colour, so it becomes
  // transparent (or the backdrop colour of its palette, for scroll).
  always_comb begin
    char_m = char_pxl;
    scr_m  = scr_pxl;
    obj_m  = obj_pxl;
`ifdef JTDD_LAYERMASK_EN
    if (!gfx_en[0]) char_m[3:0] = 4'h0;
    if (!gfx_en[1]) scr_m[3:0]  = 4'h0;
    if (!gfx_en[2]) obj_m[3:0]  = 4'h0;
`endif
  end

  // S0: palette index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          idx_s0 <= 9'h0;
    else if (pxl_cen) idx_s0 <= mix_index(char_m, scr_m, obj_m);
  end

  assign we_rg = cpu.pal_cs && !cpu.cpu_wrn && !cpu.cpu_AB[9];
  assign we_b  = cpu.pal_cs && !cpu.cpu_wrn &&  cpu.cpu_AB[9];

  // S1: both banks are read by the video port on pxl_cen, independent of the CPU port
  jtframe_dual_ram #(.dw(8), .aw(9)) u_rg_ram (
    .clk0  (clk),
    .data0 (cpu.cpu_dout),
    .addr0 (cpu.cpu_AB[8:0]),
    .we0   (we_rg),
    .q0    (rg_cq),
    .clk1  (clk),
    .cen1  (pxl_cen),
    .addr1 (idx_s0),
    .q1    (rg_vq)
  );

  jtframe_dual_ram #(.dw(8), .aw(9)) u_b_ram (
    .clk0  (clk),
    .data0 (cpu.cpu_dout),
    .addr0 (cpu.cpu_AB[8:0]),
    .we0   (we_b),
    .q0    (b_cq),
    .clk1  (clk),
    .cen1  (pxl_cen),
    .addr1 (idx_s0),
    .q1    (b_vq)
  );

  assign unused_b_hi = b_vq[7:4];

  // The RAM read registers are not reset, so rd_ok masks pal_dout until the
  // first read after reset has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_ok   <= 1'b0;
    end else begin
      rd_bank <= cpu.cpu_AB[9];
      rd_ok   <= 1'b1;
    end
  end

  assign cpu.pal_dout = !rd_ok ? 8'h00 : (rd_bank ? b_cq : rg_cq);

  // Active-low blank shift registers; resetting them to 0 also blanks the
  // first pixels after reset until valid data has filled the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhb <= '0;
      lvb <= '0;
    end else if (pxl_cen) begin
      lhb <= {lhb[PIPE_DLY-2:0], ~HBL};
      lvb <= {lvb[PIPE_DLY-2:0], ~VBL};
    end
  end

  assign LHBL_dly = lhb[PIPE_DLY-1];
  assign LVBL_dly = lvb[PIPE_DLY-1];

  // The stage feeding the last tap is the blank state that LHBL/LVBL_dly will
  // show alongside the colour loaded on this same tick.
  assign blank_s2 = !lhb[PIPE_DLY-2] || !lvb[PIPE_DLY-2];

  // S2: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (pxl_cen) begin
      if (blank_s2) begin
        red   <= 4'h0;
        green <= 4'h0;
        blue  <= 4'h0;
      end else begin
        red   <= rg_vq[3:0];
        green <= rg_vq[7:4];
        blue  <= b_vq[3:0];
      end
    end
  end

endmodule

// File: tb/tb_jtdd_colmix.sv
// tb/tb_jtdd_colmix.sv - directed self-checking bench for jtdd_colmix (JTDD_LAYERMASK_EN optional)
module tb_jtdd_colmix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic [6:0] char_pxl, scr_pxl;
  logic [7:0] obj_pxl;
  logic       HBL, VBL;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;
  logic [11:0] rgb_o;
`ifdef JTDD_LAYERMASK_EN
  logic [2:0] gfx_en;
`endif

  int vectors = 0;
  int miscompares = 0;

  jtdd_colmix_if cpu_if();

  jtdd_colmix dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .cpu      (cpu_if),
    .char_pxl (char_pxl),
    .scr_pxl  (scr_pxl),
    .obj_pxl  (obj_pxl),
    .HBL      (HBL),
    .VBL      (VBL),
`ifdef JTDD_LAYERMASK_EN
    .gfx_en   (gfx_en),
`endif
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  assign rgb_o = {red, green, blue};

  always #5 clk = ~clk;

  // pixel enable every second clk, changed on the falling edge
  always @(negedge clk) pxl_cen = ~pxl_cen;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // advance one pixel: wait for a pxl_cen rising edge, return on the following falling edge
  task automatic pix();
    @(posedge clk);
    while (!pxl_cen) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
    cpu_if.cpu_AB   = a;
    cpu_if.cpu_dout = d;
    cpu_if.pal_cs   = 1'b1;
    cpu_if.cpu_wrn  = 1'b0;
    @(negedge clk);
    cpu_if.pal_cs   = 1'b0;
    cpu_if.cpu_wrn  = 1'b1;
  endtask

  task automatic set_pix(input logic [6:0] c, input logic [7:0] o, input logic [6:0] s);
    char_pxl = c;
    obj_pxl  = o;
    scr_pxl  = s;
  endtask

  task automatic show(input string tag, input logic [6:0] c, input logic [7:0] o,
                      input logic [6:0] s, input logic [11:0] exp);
    set_pix(c, o, s);
    pix(); pix(); pix();
    chk(tag, rgb_o, exp);
  endtask

  logic [9:0] wa [10] = '{10'h105, 10'h305, 10'h037, 10'h237, 10'h192,
                          10'h392, 10'h190, 10'h390, 10'h180, 10'h380};
  logic [7:0] wd [10] = '{8'hA5, 8'h03, 8'h21, 8'h0C, 8'h7E,
                          8'h09, 8'h4B, 8'h06, 8'h00, 8'h00};

  initial begin
    cpu_if.cpu_AB   = 10'h0;
    cpu_if.cpu_dout = 8'h0;
    cpu_if.pal_cs   = 1'b0;
    cpu_if.cpu_wrn  = 1'b1;
    HBL = 1'b0;
    VBL = 1'b0;
    set_pix(7'h0, 8'h0, 7'h0);
`ifdef JTDD_LAYERMASK_EN
    gfx_en = 3'b111;
`endif
    @(negedge clk); @(negedge clk);

    chk("rst_red", red, 4'h0);
    chk("rst_green", green, 4'h0);
    chk("rst_blue", blue, 4'h0);
    chk("rst_lhbl", LHBL_dly, 1'b0);
    chk("rst_lvbl", LVBL_dly, 1'b0);
    chk("rst_pal_dout", cpu_if.pal_dout, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cpu_wr(wa[i], wd[i]);

    // CPU read-back, with one clk of latency
    cpu_if.cpu_AB = 10'h105;
    @(negedge clk);
    chk("rd_rg105", cpu_if.pal_dout, 8'hA5);
    cpu_if.cpu_AB = 10'h305;
    #1 chk("rd_latency", cpu_if.pal_dout, 8'hA5);
    @(negedge clk);
    chk("rd_b105", cpu_if.pal_dout, 8'h03);

    // let backdrop 0x180 (colour 0) fill the pipeline, then check latency
    pix(); pix(); pix();
    set_pix(7'h05, 8'h37, 7'h12);
    pix(); pix();
    chk("lat_2cen", rgb_o, 12'h000);
    pix();
    chk("char_wins", rgb_o, 12'h5A3);
    chk("lhbl_idle", LHBL_dly, 1'b1);
    chk("lvbl_idle", LVBL_dly, 1'b1);

    show("obj_wins", 7'h50, 8'h37, 7'h12, 12'h12C);
    show("scr_fallback", 7'h50, 8'h30, 7'h12, 12'hE79);
    show("scr_backdrop", 7'h00, 8'h30, 7'h10, 12'hB46);

    // 8-pixel HBL pulse and a 1-pixel VBL pulse
    show("pre_blank", 7'h05, 8'h37, 7'h12, 12'h5A3);
    for (int k = 0; k < 18; k++) begin
      HBL = (k >= 2 && k < 10);
      VBL = (k == 13);
      pix();
      chk($sformatf("hbl_k%0d", k), LHBL_dly, !(k >= 4 && k < 12));
      chk($sformatf("vbl_k%0d", k), LVBL_dly, (k != 15));
      chk($sformatf("blank_rgb_k%0d", k), rgb_o,
          ((k >= 4 && k < 12) || k == 15) ? 12'h000 : 12'h5A3);
    end

    // CPU write to 0x037 on the same clk the video port reads it
    set_pix(7'h50, 8'h37, 7'h12);
    pix();
    @(negedge clk);
    cpu_wr(10'h037, 8'h65);
    pix();
    chk("collide_old", rgb_o, 12'h12C);
    pix();
    chk("collide_new", rgb_o, 12'h56C);
    @(negedge clk);
    chk("cen_hold", rgb_o, 12'h56C);

    // asynchronous reset in the middle of a line
    show("pre_rst", 7'h05, 8'h37, 7'h12, 12'h5A3);
    #2 rst = 1'b1;
    #1;
    chk("arst_rgb", rgb_o, 12'h000);
    chk("arst_lhbl", LHBL_dly, 1'b0);
    chk("arst_lvbl", LVBL_dly, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pix();
    chk("post_rst_1", rgb_o, 12'h000);
    pix();
    chk("post_rst_2", rgb_o, 12'h000);
    pix();
    chk("post_rst_3", rgb_o, 12'h5A3);
    chk("post_rst_lhbl", LHBL_dly, 1'b1);
    cpu_if.cpu_AB = 10'h305;
    @(negedge clk);
    chk("ram_kept", cpu_if.pal_dout, 8'h03);

`ifdef JTDD_LAYERMASK_EN
    gfx_en = 3'b110;
    show("mask_char", 7'h05, 8'h37, 7'h12, 12'h12C);
    gfx_en = 3'b011;
    show("mask_obj", 7'h50, 8'h37, 7'h12, 12'hE79);
    gfx_en = 3'b101;
    show("mask_scr", 7'h50, 8'h30, 7'h12, 12'hB46);
    gfx_en = 3'b111;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
